trng_collector: RTL and testbench

//  Consumer end of the entropy chain: drives the enable into entUnit_noN and samples its o_random/o_enChain.
//  Von Neumann de-biases the sampled bits and packs them into WIDTH-bit words for a valid/ready sink.

---
 rtl/trng_collector.sv | 132 +++++++++++++
 tb/tb_trng_collector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collector.sv
// Entropy consumer: enables the source, samples its raw bit, Von Neumann de-biases the
// samples into WIDTH-bit words for a valid/ready sink and runs a repetition-count health test.
module trng_collector #(
   parameter int WIDTH      = 8,
   parameter int SAMPLE_DIV = 4,
   parameter int WARMUP     = 16,
   parameter int REP_LIMIT  = 8
) (
   input  logic             i_clk,
   input  logic             i_resSyncCircuit,
   input  logic             i_start,
   input  logic             i_random,
   input  logic             i_enChain,
   output logic             o_enSim,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_healthFail,
   output logic [1:0]       o_state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WARM    = 2'd1,
      ST_COLLECT = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       div_q, warm_q, run_q, run_next;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-2:0] sr_q;
   logic [WIDTH-1:0] word_next;
   logic             phase_q, first_q, prev_q;
   logic             run_en, strobe, accept, word_done, warm_done, handshake;

   // Handshake: o_data is offered while o_valid=1 and is taken on the clock edge where
   // o_valid & i_ready; o_valid never drops without that edge except on abort or reset.
   always_comb begin
      run_en    = i_start & i_enChain;
      strobe    = ((state_q == ST_WARM) || (state_q == ST_COLLECT)) &&
                  (div_q == 8'(SAMPLE_DIV - 1));
      accept    = strobe && (state_q == ST_COLLECT) && phase_q && (first_q != i_random);
      word_done = accept && (cnt_q == CW'(WIDTH - 1));
      warm_done = strobe && (state_q == ST_WARM) && (warm_q == 8'(WARMUP - 1));
      handshake = o_valid & i_ready;
      word_next = {first_q, sr_q};

      if ((run_q == 8'd0) || (prev_q != i_random)) run_next = 8'd1;
      else if (run_q == 8'hFF)                     run_next = 8'hFF;
      else                                         run_next = run_q + 8'd1;

      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (run_en)    state_d = (WARMUP == 0) ? ST_COLLECT : ST_WARM;
         ST_WARM:    if (warm_done) state_d = ST_COLLECT;
         ST_COLLECT: if (word_done) state_d = ST_HOLD;
         ST_HOLD:    if (handshake) state_d = ST_COLLECT;
         default:                   state_d = ST_IDLE;
      endcase
      if (!run_en) state_d = ST_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_resSyncCircuit) begin
         state_q      <= ST_IDLE;
         o_enSim      <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_healthFail <= 1'b0;
         div_q        <= 8'd0;
         warm_q       <= 8'd0;
         run_q        <= 8'd0;
         cnt_q        <= '0;
         sr_q         <= '0;
         phase_q      <= 1'b0;
         first_q      <= 1'b0;
         prev_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         o_enSim <= i_start;
         if (state_d == ST_IDLE) begin
            // Abort or idle: drop partial word, pair and any pending word; health flag persists.
            div_q   <= 8'd0;
            warm_q  <= 8'd0;
            run_q   <= 8'd0;
            cnt_q   <= '0;
            sr_q    <= '0;
            phase_q <= 1'b0;
            o_valid <= 1'b0;
         end else begin
            if (strobe) div_q <= 8'd0;
            else if ((state_q == ST_WARM) || (state_q == ST_COLLECT)) div_q <= div_q + 8'd1;

            if (strobe) begin
               prev_q <= i_random;
               run_q  <= run_next;
               if (run_next >= 8'(REP_LIMIT)) o_healthFail <= 1'b1;
            end

            if (strobe && (state_q == ST_WARM)) warm_q <= warm_q + 8'd1;
            if (warm_done) phase_q <= 1'b0;

            if (strobe && (state_q == ST_COLLECT)) begin
               phase_q <= ~phase_q;
               if (!phase_q) first_q <= i_random;
            end

            if (accept) begin
               sr_q  <= word_next[WIDTH-1:1];
               cnt_q <= cnt_q + CW'(1);
            end

            if (word_done) begin
               o_data  <= word_next;
               o_valid <= 1'b1;
            end

            if ((state_q == ST_HOLD) && handshake) begin
               o_valid <= 1'b0;
               cnt_q   <= '0;
               phase_q <= 1'b0;
            end
         end
      end
   end

   assign o_state = state_q;

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: two instances (fast no-warmup and warmup/health),
// de-biased words predicted from driven pairs into an expected queue.
module tb_trng_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_start, a_en, a_rand, a_ready, a_ensim, a_valid, a_hf;
   logic [7:0] a_data;
   logic [1:0] a_state;
   logic       b_start, b_en, b_rand, b_ready, b_ensim, b_valid, b_hf;
   logic [7:0] b_data;
   logic [1:0] b_state;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] m_word;
   int         m_cnt;
   logic [7:0] last_word;
   logic       seen_valid;
   logic [19:0] p2;
   logic [15:0] p6, p5;

   trng_collector #(.WIDTH(8), .SAMPLE_DIV(1), .WARMUP(0), .REP_LIMIT(8)) dut_a (
      .i_clk(clk), .i_resSyncCircuit(rst), .i_start(a_start), .i_random(a_rand),
      .i_enChain(a_en), .o_enSim(a_ensim), .o_data(a_data), .o_valid(a_valid),
      .i_ready(a_ready), .o_healthFail(a_hf), .o_state(a_state));

   trng_collector #(.WIDTH(8), .SAMPLE_DIV(2), .WARMUP(16), .REP_LIMIT(8)) dut_b (
      .i_clk(clk), .i_resSyncCircuit(rst), .i_start(b_start), .i_random(b_rand),
      .i_enChain(b_en), .o_enSim(b_ensim), .o_data(b_data), .o_valid(b_valid),
      .i_ready(b_ready), .o_healthFail(b_hf), .o_state(b_state));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_pair(input logic f, input logic s);
      if (f != s) begin
         m_word[m_cnt] = f;
         m_cnt++;
         if (m_cnt == 8) begin
            exp_q.push_back(m_word);
            m_cnt  = 0;
            m_word = 8'h00;
         end
      end
   endtask

   task automatic model_clear();
      m_cnt  = 0;
      m_word = 8'h00;
   endtask

   task automatic a_strobe(input logic b);
      a_rand = b;
      tick();
   endtask

   task automatic a_pair(input logic f, input logic s);
      model_pair(f, s);
      a_strobe(f);
      a_strobe(s);
   endtask

   task automatic b_strobe(input logic b);
      b_rand = b;
      tick();
      tick();
   endtask

   task automatic b_pair(input logic f, input logic s);
      model_pair(f, s);
      b_strobe(f);
      b_strobe(s);
   endtask

   task automatic wait_a_state(input logic [1:0] st, input string tag);
      int k = 0;
      while ((a_state !== st) && (k < 100)) begin
         tick();
         k++;
      end
      check(tag, 32'(a_state), 32'(st));
   endtask

   task automatic pop_check(input string tag, input logic [7:0] data, input logic valid);
      check({tag, "_valid"}, 32'(valid), 1);
      check({tag, "_qsize"}, 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) begin
         last_word = exp_q.pop_front();
         check({tag, "_data"}, 32'(data), 32'(last_word));
      end
   endtask

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_en = 1'b0; a_rand = 1'b0; a_ready = 1'b0;
      b_start = 1'b0; b_en = 1'b0; b_rand = 1'b0; b_ready = 1'b0;
      model_clear();
      last_word = 8'h00;
      repeat (3) tick();
      check("rst_state", 32'(a_state), 0);
      check("rst_valid", 32'(a_valid), 0);
      check("rst_health", 32'(a_hf), 0);
      check("rst_ensim", 32'(a_ensim), 0);
      rst = 1'b0;
      tick();

      // Directed word: pairs 10,01,11,10,00,01,01,10,10,01
      a_start = 1'b1;
      a_en    = 1'b1;
      wait_a_state(2'd2, "t2_enter_collect");
      check("t2_ensim", 32'(a_ensim), 1);
      p2 = 20'b10_01_11_10_00_01_01_10_10_01;
      for (int i = 9; i >= 0; i--) a_pair(p2[2*i+1], p2[2*i]);
      pop_check("t2_word", a_data, a_valid);
      check("t2_hold", 32'(a_state), 3);
      check("t2_health", 32'(a_hf), 0);

      // Backpressure: word held while the source keeps toggling
      for (int i = 0; i < 50; i++) begin
         a_rand = 1'($urandom_range(0, 1));
         tick();
      end
      check("t3_data_held", 32'(a_data), 32'(last_word));
      check("t3_valid_held", 32'(a_valid), 1);
      check("t3_state_held", 32'(a_state), 3);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("t3_hs_valid", 32'(a_valid), 0);
      check("t3_hs_state", 32'(a_state), 2);
      check("t3_hs_data", 32'(a_data), 32'(last_word));

      // Random second word
      for (int i = 0; i < 200 && exp_q.size() == 0; i++)
         a_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pop_check("t3_rand_word", a_data, a_valid);

      // Reset while holding a word
      rst = 1'b1;
      tick();
      tick();
      check("t1_valid", 32'(a_valid), 0);
      check("t1_data", 32'(a_data), 0);
      check("t1_state", 32'(a_state), 0);
      check("t1_ensim", 32'(a_ensim), 0);
      exp_q.delete();
      model_clear();
      rst = 1'b0;

      // Abort after 3 bits, then a fresh word
      wait_a_state(2'd2, "t6_enter_collect");
      a_pair(1'b1, 1'b0);
      a_pair(1'b0, 1'b1);
      a_pair(1'b1, 1'b0);
      a_en = 1'b0;
      tick();
      check("t6_abort_state", 32'(a_state), 0);
      check("t6_abort_valid", 32'(a_valid), 0);
      model_clear();
      a_en = 1'b1;
      wait_a_state(2'd2, "t6_reenter_collect");
      p6 = 16'b01_01_10_01_10_10_01_01;
      for (int i = 7; i >= 0; i--) a_pair(p6[2*i+1], p6[2*i]);
      pop_check("t6_word", a_data, a_valid);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("t6_hs_state", 32'(a_state), 2);

      // Word completion coinciding with i_start falling
      for (int i = 0; i < 7; i++) a_pair(1'b1, 1'b0);
      a_strobe(1'b1);
      a_rand  = 1'b0;
      a_start = 1'b0;
      tick();
      check("sim_valid", 32'(a_valid), 0);
      check("sim_state", 32'(a_state), 0);
      check("sim_ensim", 32'(a_ensim), 0);
      model_clear();

      // Warmup: 16 discarded strobes at SAMPLE_DIV=2
      b_start = 1'b1;
      b_en    = 1'b1;
      tick();
      check("t5_enter_warm", 32'(b_state), 1);
      check("t5_ensim", 32'(b_ensim), 1);
      seen_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b_strobe(1'(i % 2));
         if (b_valid) seen_valid = 1'b1;
         if (i == 14) check("t5_still_warm", 32'(b_state), 1);
      end
      check("t5_collect", 32'(b_state), 2);
      check("t5_no_early_valid", 32'(seen_valid), 0);
      p5 = 16'b10_01_01_10_01_10_01_10;
      for (int i = 7; i >= 0; i--) b_pair(p5[2*i+1], p5[2*i]);
      pop_check("t5_word", b_data, b_valid);
      check("t5_health", 32'(b_hf), 0);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("t5_hs_state", 32'(b_state), 2);

      // Health: stuck-at-1 trips on the 8th identical sample, sticky past stop
      for (int i = 0; i < 7; i++) b_strobe(1'b1);
      check("t4_health_7", 32'(b_hf), 0);
      b_strobe(1'b1);
      check("t4_health_8", 32'(b_hf), 1);
      b_start = 1'b0;
      tick();
      check("t4_stop_state", 32'(b_state), 0);
      check("t4_stop_ensim", 32'(b_ensim), 0);
      check("t4_sticky", 32'(b_hf), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
